// File: rtl/lifo_fifo_pkg.sv
// ============================================================================
// Package     : lifo_fifo_pkg
// Description : Shared order-mode type and default sizing for the LIFO/FIFO buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lifo_fifo_pkg;

    typedef enum logic {
        MODE_FIFO = 1'b0,
        MODE_LIFO = 1'b1
    } mode_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

endpackage

`default_nettype wire

// File: rtl/lifo_fifo_mem.sv
// ============================================================================
// Module      : lifo_fifo_mem
// Description : DEPTH x DATA_W register file, one write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lifo_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reading in the same edge as a write to that address yields the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/lifo_fifo_buffer.sv
// ============================================================================
// Module      : lifo_fifo_buffer
// Description : Single-clock buffer switchable between FIFO and LIFO order.
//               Define LIFO_FIFO_ERR_EN to enable sticky ovf_o/unf_o error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lifo_fifo_buffer
    import lifo_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [DATA_W-1:0]      push_data_i,
    input  logic                   pop_i,
    output logic [DATA_W-1:0]      pop_data_o,
    output logic                   pop_valid_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   ovf_o,
    output logic                   unf_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    mode_e             mode_q, mode_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              pop_valid_q;

    logic              push_acc;
    logic              pop_acc;
    logic [ADDR_W-1:0] lifo_top;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] mem_raddr;

    always_comb begin
        push_acc  = push_i && (!full_q || pop_i) && !flush_i;
        pop_acc   = pop_i && !empty_q && !flush_i;
        lifo_top  = count_q[ADDR_W-1:0] - ADDR_W'(1);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mem_waddr = wr_ptr_q;
        mem_raddr = rd_ptr_q;

        // Order can only change while the buffer is idle and empty.
        mode_d = (empty_q && !push_i) ? mode_e'(mode_i) : mode_q;

        if (mode_q == MODE_LIFO) begin
            mem_raddr = lifo_top;
            mem_waddr = pop_acc ? lifo_top : count_q[ADDR_W-1:0];
        end

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (mode_q == MODE_FIFO) begin
                if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (pop_acc)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mode_q      <= MODE_FIFO;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pop_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            pop_valid_q <= pop_acc;
        end
    end

    lifo_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (push_acc),
        .waddr_i (mem_waddr),
        .wdata_i (push_data_i),
        .re_i    (pop_acc),
        .raddr_i (mem_raddr),
        .rdata_o (pop_data_o)
    );

`ifdef LIFO_FIFO_ERR_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push_i && !push_acc) ovf_q <= 1'b1;
            if (pop_i && empty_q)    unf_q <= 1'b1;
        end
    end

    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
`else
    assign ovf_o = 1'b0;
    assign unf_o = 1'b0;
`endif

    assign pop_valid_o = pop_valid_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign count_o     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_lifo_fifo_buffer.sv
// ============================================================================
// Module      : tb_lifo_fifo_buffer
// Description : Self-checking bench for lifo_fifo_buffer (DATA_W=8, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lifo_fifo_buffer;

    localparam int DEPTH = 4;
`ifdef LIFO_FIFO_ERR_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       push_i = 1'b0;
    logic [7:0] push_data_i = '0;
    logic       pop_i = 1'b0;
    logic [7:0] pop_data_o;
    logic       pop_valid_o;
    logic       full_o;
    logic       empty_o;
    logic [2:0] count_o;
    logic       ovf_o;
    logic       unf_o;

    int total = 0;
    int bad   = 0;

    // reference model: queue holds entries oldest (front) .. newest (back)
    logic [7:0] mq[$];
    bit         m_lifo;
    logic [7:0] m_pd;
    bit         m_pv;
    bit         m_ovf;
    bit         m_unf;

    always #5 clk = ~clk;

    lifo_fifo_buffer #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_i      (mode_i),
        .flush_i     (flush_i),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .pop_i       (pop_i),
        .pop_data_o  (pop_data_o),
        .pop_valid_o (pop_valid_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .ovf_o       (ovf_o),
        .unf_o       (unf_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit rs, input bit md, input bit fl,
                                input bit pu, input logic [7:0] d, input bit po);
        bit is_full, is_empty, pa, oa, next_lifo;
        if (!rs) begin
            mq.delete();
            m_lifo = 1'b0;
            m_pd   = 8'h00;
            m_pv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            return;
        end
        is_full   = (mq.size() == DEPTH);
        is_empty  = (mq.size() == 0);
        next_lifo = (is_empty && !pu) ? md : m_lifo;
        if (fl) begin
            mq.delete();
            m_pv  = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pa = pu && (!is_full || po);
            oa = po && !is_empty;
            if (ERR_EXP && pu && !pa)    m_ovf = 1'b1;
            if (ERR_EXP && po && is_empty) m_unf = 1'b1;
            m_pv = oa;
            if (oa) m_pd = m_lifo ? mq.pop_back() : mq.pop_front();
            if (pa) mq.push_back(d);
        end
        m_lifo = next_lifo;
    endtask

    task automatic check_model();
        chk("pop_valid", pop_valid_o, m_pv);
        chk("pop_data",  pop_data_o,  m_pd);
        chk("count",     count_o,     mq.size());
        chk("full",      full_o,      mq.size() == DEPTH);
        chk("empty",     empty_o,     mq.size() == 0);
        chk("ovf",       ovf_o,       m_ovf);
        chk("unf",       unf_o,       m_unf);
    endtask

    task automatic step(input bit rs, input bit md, input bit fl,
                        input bit pu, input logic [7:0] d, input bit po);
        @(negedge clk);
        rst_n = rs; mode_i = md; flush_i = fl;
        push_i = pu; push_data_i = d; pop_i = po;
        @(posedge clk);
        model_update(rs, md, fl, pu, d, po);
        #1;
        check_model();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    initial begin
        int nxt;
        int cyc;
        int maxc;
        int got[$];
        logic [7:0] exp_fill[4];
        logic [7:0] exp_lifo[3];

        exp_fill[0] = 8'h11; exp_fill[1] = 8'h22; exp_fill[2] = 8'h33; exp_fill[3] = 8'h44;
        exp_lifo[0] = 8'hC3; exp_lifo[1] = 8'hB2; exp_lifo[2] = 8'hA1;

        // reset state
        step(0, 0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 8'h00, 0);
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full",  full_o,  0);
        chk("rst_valid", pop_valid_o, 0);

        // FIFO fill, overflow, drain
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, exp_fill[i], 0);
        chk("fill_full",  full_o,  1);
        chk("fill_count", count_o, 4);
        step(1, 0, 0, 1, 8'h55, 0);
        chk("fill_rej_count", count_o, 4);
        chk("fill_ovf", ovf_o, ERR_EXP);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 8'h00, 1);
            chk("fifo_pop_data",  pop_data_o,  exp_fill[i]);
            chk("fifo_pop_valid", pop_valid_o, 1);
        end
        step(1, 0, 0, 0, 8'h00, 0);
        chk("fifo_idle_valid", pop_valid_o, 0);
        chk("fifo_drain_empty", empty_o, 1);

        // LIFO order and underflow
        step(1, 1, 0, 0, 8'h00, 0);
        step(1, 1, 0, 1, 8'hA1, 0);
        step(1, 1, 0, 1, 8'hB2, 0);
        step(1, 1, 0, 1, 8'hC3, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 8'h00, 1);
            chk("lifo_pop_data", pop_data_o, exp_lifo[i]);
        end
        chk("lifo_empty", empty_o, 1);
        step(1, 1, 0, 0, 8'h00, 1);
        chk("lifo_unf_valid", pop_valid_o, 0);
        chk("lifo_unf", unf_o, ERR_EXP);

        // LIFO replace-top
        step(1, 1, 0, 1, 8'h10, 0);
        step(1, 1, 0, 1, 8'h20, 0);
        step(1, 1, 0, 1, 8'h99, 1);
        chk("rt_data",  pop_data_o, 8'h20);
        chk("rt_count", count_o, 2);
        step(1, 1, 0, 0, 8'h00, 1);
        chk("rt_next", pop_data_o, 8'h99);
        step(1, 1, 0, 0, 8'h00, 1);
        chk("rt_last", pop_data_o, 8'h10);

        // back to FIFO, clear sticky flags
        step(1, 0, 1, 0, 8'h00, 0);

        // FIFO wrap with a pop every second cycle
        nxt = 1; cyc = 0; maxc = 0;
        while (got.size() < 10 && cyc < 100) begin
            bit po, pu;
            po = cyc[0];
            pu = (nxt <= 10) && (mq.size() < DEPTH || po);
            step(1, 0, 0, pu, 8'(nxt), po);
            if (pu) nxt++;
            if (pop_valid_o) got.push_back(int'(pop_data_o));
            if (int'(count_o) > maxc) maxc = int'(count_o);
            cyc++;
        end
        chk("wrap_n", got.size(), 10);
        for (int i = 0; i < got.size(); i++) chk("wrap_data", got[i], i + 1);
        chk("wrap_maxcnt_le4", maxc <= 4, 1);

        // FIFO full push+pop
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 8'(8'h51 + i), 0);
        step(1, 0, 0, 1, 8'h55, 1);
        chk("ff_data",  pop_data_o, 8'h51);
        chk("ff_count", count_o, 4);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'h00, 1);
        chk("ff_tail", pop_data_o, 8'h55);

        // mode lock: mode_i=1 while occupied must not change order
        step(1, 0, 0, 1, 8'h61, 0);
        step(1, 1, 0, 1, 8'h62, 0);
        step(1, 1, 0, 0, 8'h00, 1);
        chk("lock_pop0", pop_data_o, 8'h61);
        step(1, 1, 0, 0, 8'h00, 1);
        chk("lock_pop1", pop_data_o, 8'h62);
        step(1, 1, 0, 0, 8'h00, 0);
        step(1, 1, 0, 1, 8'h71, 0);
        step(1, 1, 0, 1, 8'h72, 0);
        step(1, 1, 0, 0, 8'h00, 1);
        chk("lock_lifo", pop_data_o, 8'h72);

        // flush with 3 entries and overflow set, then reset mid-pop
        step(1, 0, 1, 0, 8'h00, 0);
        step(1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 8'(8'h81 + i), 0);
        step(1, 0, 0, 0, 8'h00, 1);
        chk("pre_flush_count", count_o, 3);
        step(1, 0, 1, 1, 8'hEE, 1);
        chk("flush_count", count_o, 0);
        chk("flush_empty", empty_o, 1);
        chk("flush_ovf",   ovf_o, 0);
        chk("flush_valid", pop_valid_o, 0);
        chk("flush_hold",  pop_data_o, 8'h81);
        step(1, 0, 0, 1, 8'h91, 0);
        step(1, 0, 0, 1, 8'h92, 0);
        step(0, 0, 0, 0, 8'h00, 1);
        chk("rst_mid_valid", pop_valid_o, 0);
        chk("rst_mid_data",  pop_data_o, 8'h00);
        chk("rst_mid_count", count_o, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit rs, md, fl, pu, po;
            rs = ($urandom_range(63) != 0);
            fl = ($urandom_range(19) == 0);
            md = $urandom_range(1);
            pu = $urandom_range(1);
            po = $urandom_range(1);
            step(rs, md, fl, pu, 8'($urandom), po);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
